// File: rtl/coax_tx_buffer.sv
// ----------------------------------------------------------------------------
// coax_tx_buffer
// Message FIFO feeding coax_tx. Host writes 10-bit words tagged with an
// end-of-message bit. Draining starts only once a complete message is held
// (or the FIFO is full), so coax_tx receives the words of a message back to
// back over a data/strobe/ready handshake.
//
// Parameters:
//   DEPTH    FIFO depth in words (power of two, >= 4)
//   HOLDOFF  cycles after tx_strobe during which tx_ready is ignored
//
// Ports:
//   i_clk           system clock
//   i_reset         synchronous, active-high reset
//   i_write_data    coax word to enqueue
//   i_write_last    word is the final word of its message
//   i_write_strobe  enqueue i_write_data/i_write_last this cycle
//   o_full          FIFO holds DEPTH words
//   o_empty         FIFO holds 0 words
//   o_tx_data       word presented to coax_tx (holds last strobed value)
//   o_tx_strobe     one-cycle pulse: coax_tx latches o_tx_data
//   i_tx_ready      coax_tx can accept the next word
//   o_overflow      sticky: write attempted while full
//
// Build option: define COAX_TX_BUFFER_OVERFLOW_EN to enable the sticky
// overflow flag; otherwise o_overflow is tied to 0.
// ----------------------------------------------------------------------------
module coax_tx_buffer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_write_data,
    input  logic       i_write_last,
    input  logic       i_write_strobe,
    output logic       o_full,
    output logic       o_empty,
    output logic [9:0] o_tx_data,
    output logic       o_tx_strobe,
    input  logic       i_tx_ready,
    output logic       o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HoldLast = HW'(HOLDOFF - 1);
    localparam logic [AW:0]   PtrOne   = (AW + 1)'(1);
    localparam logic [CW-1:0] CntOne   = CW'(1);

    typedef enum logic [1:0] {StIdle, StStrobe, StHold, StWait} state_t;

    logic [10:0]   r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [CW-1:0] r_msg_count;
    state_t        r_state;
    logic          r_in_last;
    logic [HW-1:0] r_hold_cnt;
    logic [9:0]    r_tx_data;
    logic          r_tx_strobe;

    logic        w_empty;
    logic        w_full;
    logic [10:0] w_head;
    logic        w_wr_en;
    logic        w_start;
    logic        w_pop;
    logic        w_inc;
    logic        w_dec;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
    // A write while full is dropped even if a pop happens in the same cycle.
    assign w_wr_en = i_write_strobe && !w_full;
    // Full with no complete message still starts a drain (message > DEPTH).
    assign w_start = !w_empty && ((r_msg_count != '0) || w_full) && i_tx_ready;
    // The head is popped on the edge that raises tx_strobe.
    assign w_pop   = ((r_state == StIdle) && w_start) ||
                     ((r_state == StWait) && i_tx_ready && !r_in_last && !w_empty);
    assign w_inc   = w_wr_en && i_write_last;
    assign w_dec   = w_pop && w_head[10];

    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_reset) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {i_write_last, i_write_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_msg_count <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PtrOne;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PtrOne;
            case ({w_inc, w_dec})
                2'b10:   r_msg_count <= r_msg_count + CntOne;
                2'b01:   r_msg_count <= r_msg_count - CntOne;
                default: r_msg_count <= r_msg_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_in_last   <= 1'b0;
            r_hold_cnt  <= '0;
            r_tx_data   <= '0;
            r_tx_strobe <= 1'b0;
        end else begin
            r_tx_strobe <= 1'b0;
            if (w_pop) begin
                r_tx_strobe <= 1'b1;
                r_tx_data   <= w_head[9:0];
                r_in_last   <= w_head[10];
            end
            case (r_state)
                StIdle: begin
                    if (w_start) r_state <= StStrobe;
                end
                StStrobe: begin
                    r_hold_cnt <= '0;
                    r_state    <= (HOLDOFF == 0) ? StWait : StHold;
                end
                StHold: begin
                    if (r_hold_cnt == HoldLast) begin
                        r_state <= StWait;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                StWait: begin
                    // Empty mid-message: stay here until the next word arrives.
                    if (i_tx_ready) begin
                        if (r_in_last)     r_state <= StIdle;
                        else if (!w_empty) r_state <= StStrobe;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef COAX_TX_BUFFER_OVERFLOW_EN
    logic r_overflow;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (i_write_strobe && w_full) begin
            r_overflow <= 1'b1;
        end
    end
    assign o_overflow = r_overflow;
`else
    assign o_overflow = 1'b0;
`endif

    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_tx_data   = r_tx_data;
    assign o_tx_strobe = r_tx_strobe;

endmodule

// File: tb/tb_coax_tx_buffer.sv
// ----------------------------------------------------------------------------
// tb_coax_tx_buffer
// Self-checking bench for coax_tx_buffer. A queue-based reference model tracks
// the buffered words; a monitor checks every strobed word, strobe spacing,
// tx_data hold, and the empty/full/overflow flags every cycle. Scenario tasks
// cover reset, message gating, latency, full-start, overflow and mid-message
// reset, followed by a randomized traffic run.
// ----------------------------------------------------------------------------
module tb_coax_tx_buffer;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned HOLDOFF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] write_data = '0;
    logic       write_last = 1'b0;
    logic       write_strobe = 1'b0;
    logic       tx_ready = 1'b0;
    logic       full;
    logic       empty;
    logic [9:0] tx_data;
    logic       tx_strobe;
    logic       overflow;

    coax_tx_buffer #(
        .DEPTH   (DEPTH),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_write_data   (write_data),
        .i_write_last   (write_last),
        .i_write_strobe (write_strobe),
        .o_full         (full),
        .o_empty        (empty),
        .o_tx_data      (tx_data),
        .o_tx_strobe    (tx_strobe),
        .i_tx_ready     (tx_ready),
        .o_overflow     (overflow)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int strobe_cnt = 0;
    int strobe_cyc[$];
    logic [10:0] mq[$];
    bit ovf_exp = 1'b0;
    logic [9:0] data_hold = '0;

    // Reference model: FIFO of {last,data} updated at each active edge.
    initial begin : model
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
                ovf_exp = 1'b0;
                data_hold = '0;
                strobe_cyc.delete();
            end else if (write_strobe) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({write_last, write_data});
                end else begin
`ifdef COAX_TX_BUFFER_OVERFLOW_EN
                    ovf_exp = 1'b1;
`endif
                end
            end
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        logic [10:0] e;
        int d;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (tx_strobe === 1'b1) begin
                    strobe_cnt++;
                    strobe_cyc.push_back(cyc);
                    checks++;
                    if (mq.size() == 0) begin
                        errors++;
                        $display("FAIL strobe_underrun: strobe with tx_data=%h, model holds no word",
                                 tx_data);
                    end else begin
                        e = mq.pop_front();
                        data_hold = e[9:0];
                        if (tx_data !== e[9:0]) begin
                            errors++;
                            $display("FAIL tx_data: got %h, expected %h", tx_data, e[9:0]);
                        end
                    end
                    if (strobe_cyc.size() >= 2) begin
                        d = strobe_cyc[strobe_cyc.size()-1] - strobe_cyc[strobe_cyc.size()-2];
                        checks++;
                        if (d < int'(HOLDOFF + 2)) begin
                            errors++;
                            $display("FAIL strobe_spacing: got %0d cycles, minimum %0d",
                                     d, HOLDOFF + 2);
                        end
                    end
                end else begin
                    checks++;
                    if (tx_strobe !== 1'b0 || tx_data !== data_hold) begin
                        errors++;
                        $display("FAIL tx_hold: strobe=%b data=%h, expected strobe=0 data=%h",
                                 tx_strobe, tx_data, data_hold);
                    end
                end
                checks++;
                if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                    errors++;
                    $display("FAIL flags: empty=%b full=%b, expected empty=%b full=%b (%0d words)",
                             empty, full, mq.size() == 0, mq.size() == DEPTH, mq.size());
                end
                checks++;
                if (overflow !== ovf_exp) begin
                    errors++;
                    $display("FAIL overflow: got %b, expected %b", overflow, ovf_exp);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks run at negedge+1 so monitor updates are already visible.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic write_word(input logic [9:0] d, input logic l);
        write_data   = d;
        write_last   = l;
        write_strobe = 1'b1;
        tick(1);
        write_strobe = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (strobe_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d strobes, expected %0d", name, strobe_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(8);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || tx_strobe !== 1'b0 ||
            overflow !== 1'b0 || tx_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_state: empty=%b full=%b strobe=%b ovf=%b data=%h, expected 1 0 0 0 000",
                     empty, full, tx_strobe, overflow, tx_data);
        end
    endtask

    task automatic test_latency();
        int s0;
        int cw;
        tx_ready = 1'b1;
        tick(2);
        s0 = strobe_cnt;
        write_word(10'h175, 1'b0);
        tick(20);
        checks++;
        if (strobe_cnt != s0) begin
            errors++;
            $display("FAIL partial_msg_gate: got %0d strobes, expected 0", strobe_cnt - s0);
        end
        cw = cyc;
        write_word(10'h28E, 1'b1);
        wait_strobes(s0 + 2, 40, "latency");
        checks++;
        if (strobe_cyc.size() < 2 || strobe_cyc[strobe_cyc.size()-2] != cw + 2) begin
            errors++;
            $display("FAIL first_latency: strobe at cycle %0d, expected %0d",
                     (strobe_cyc.size() >= 2) ? strobe_cyc[strobe_cyc.size()-2] : -1, cw + 2);
        end
        tick(4);
        checks++;
        if (empty !== 1'b1 || strobe_cnt != s0 + 2) begin
            errors++;
            $display("FAIL latency_end: empty=%b strobes=%0d, expected empty=1 strobes=2",
                     empty, strobe_cnt - s0);
        end
    endtask

    task automatic test_ready_gate();
        int s0;
        tx_ready = 1'b0;
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) write_word(10'($urandom), i == 2);
        tick(15);
        checks++;
        if (strobe_cnt != s0) begin
            errors++;
            $display("FAIL ready_gate: got %0d strobes while not ready, expected 0", strobe_cnt - s0);
        end
        tx_ready = 1'b1;
        wait_strobes(s0 + 3, 60, "ready_gate");
        tick(10);
        checks++;
        if (strobe_cnt != s0 + 3 || empty !== 1'b1) begin
            errors++;
            $display("FAIL ready_drain: strobes=%0d empty=%b, expected 3 and 1",
                     strobe_cnt - s0, empty);
        end
        // A leftover message count would let this lone partial word go out.
        write_word(10'($urandom), 1'b0);
        tick(15);
        checks++;
        if (strobe_cnt != s0 + 3) begin
            errors++;
            $display("FAIL msg_count_zero: got %0d extra strobes, expected 0",
                     strobe_cnt - s0 - 3);
        end
        write_word(10'($urandom), 1'b1);
        wait_strobes(s0 + 5, 40, "ready_cleanup");
        tick(6);
    endtask

    task automatic test_full_start();
        int s0;
        int d;
        int bad = 0;
        tx_ready = 1'b1;
        s0 = strobe_cnt;
        for (int i = 0; i < int'(DEPTH); i++) write_word(10'($urandom), 1'b0);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL full_flag: got %b, expected 1", full);
        end
        wait_strobes(s0 + 1, 10, "full_start");
        write_word(10'($urandom), 1'b1);
        wait_strobes(s0 + DEPTH + 1, 200, "full_drain");
        for (int i = strobe_cyc.size() - int'(DEPTH); i < strobe_cyc.size(); i++) begin
            d = strobe_cyc[i] - strobe_cyc[i-1];
            if (i >= 1 && d != int'(HOLDOFF + 2)) bad++;
        end
        checks++;
        if (bad != 0 || strobe_cyc.size() < int'(DEPTH + 1)) begin
            errors++;
            $display("FAIL full_back_to_back: %0d gaps not %0d cycles (%0d strobes logged)",
                     bad, HOLDOFF + 2, strobe_cyc.size());
        end
        tick(6);
        checks++;
        if (empty !== 1'b1 || strobe_cnt != s0 + DEPTH + 1) begin
            errors++;
            $display("FAIL full_end: empty=%b strobes=%0d, expected 1 and %0d",
                     empty, strobe_cnt - s0, DEPTH + 1);
        end
    endtask

    task automatic test_overflow();
        int s0;
        logic exp_ovf;
`ifdef COAX_TX_BUFFER_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        tx_ready = 1'b0;
        s0 = strobe_cnt;
        for (int i = 0; i < int'(DEPTH); i++) write_word(10'($urandom), i == int'(DEPTH) - 1);
        write_word(10'($urandom), 1'b0);
        tick(1);
        checks++;
        if (overflow !== exp_ovf || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b full=%b, expected %b and 1", overflow, full, exp_ovf);
        end
        tx_ready = 1'b1;
        wait_strobes(s0 + DEPTH, 200, "overflow_drain");
        tick(20);
        checks++;
        if (strobe_cnt != s0 + DEPTH || empty !== 1'b1 || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL overflow_drain: strobes=%0d empty=%b ovf=%b, expected %0d 1 %b",
                     strobe_cnt - s0, empty, overflow, DEPTH, exp_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        tx_ready = 1'b1;
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) write_word(10'($urandom), i == 2);
        wait_strobes(s0 + 1, 20, "mid_first");
        tx_ready = 1'b0;
        tick(6);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (empty !== 1'b1 || tx_strobe !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: empty=%b strobe=%b ovf=%b, expected 1 0 0",
                     empty, tx_strobe, overflow);
        end
        tx_ready = 1'b1;
        tick(20);
        checks++;
        if (strobe_cnt != s0 + 1) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d strobes after reset, expected 0",
                     strobe_cnt - s0 - 1);
        end
        write_word(10'h2A5, 1'b1);
        wait_strobes(s0 + 2, 20, "mid_recover");
        tick(6);
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 800; i++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                write_data   = 10'($urandom);
                write_last   = ($urandom_range(0, 3) == 0);
                write_strobe = 1'b1;
            end else begin
                write_strobe = 1'b0;
            end
            tick(1);
        end
        write_strobe = 1'b0;
        tx_ready = 1'b1;
        n = 0;
        while (mq.size() >= DEPTH && n < 200) begin
            tick(1);
            n++;
        end
        write_word(10'($urandom), 1'b1);
        n = 0;
        while (mq.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        tick(8);
        checks++;
        if (mq.size() != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL random_drain: %0d model words left, empty=%b", mq.size(), empty);
        end
    endtask

    initial begin : main
        tick(1);
        test_reset();
        test_latency();
        test_ready_gate();
        test_full_start();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
